// File: rtl/recon_pkg.sv
// Shared constants and state encoding for the 4x4 reconstruction stage.
package recon_pkg;

  localparam int PIX_W   = 8;    // unsigned prediction / output pixel width
  localparam int RES_W   = 9;    // signed residual width from the residual decoder
  localparam int TAG_W   = 5;    // block tag: luma 0-15, chroma 16-23
  localparam int PIX_MAX = 255;  // upper clip bound for 8-bit pixels

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } state_t;

endpackage

// File: rtl/recon_clip_add.sv
// One-sample reconstruction: unsigned prediction plus signed residual,
// clipped to [0, PIX_MAX], with a flag raised whenever clipping occurred.
module recon_clip_add #(
  parameter int PIX_W   = recon_pkg::PIX_W,
  parameter int RES_W   = recon_pkg::RES_W,
  parameter int PIX_MAX = recon_pkg::PIX_MAX
) (
  input  logic [PIX_W-1:0]        pred,
  input  logic signed [RES_W-1:0] res,
  output logic [PIX_W-1:0]        pix,
  output logic                    clipped
);

  // One bit wider than the wider operand, so the sum can never overflow.
  localparam int SUM_W = ((PIX_W + 1 > RES_W) ? PIX_W + 1 : RES_W) + 1;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(PIX_MAX);

  logic signed [SUM_W-1:0] sum;

  // Extend both operands to the common signed width, add, then clip.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default before any branch, so no path can leave a latch behind.
    sum     = $signed({{(SUM_W - PIX_W){1'b0}}, pred})
            + $signed({{(SUM_W - RES_W){res[RES_W-1]}}, res});
    pix     = sum[PIX_W-1:0];
    clipped = 1'b0;
    if (sum < 0) begin
      pix     = '0;
      clipped = 1'b1;
    end else if (sum > MAX_S) begin
      pix     = PIX_W'(PIX_MAX);
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/recon_sum_4x4.sv
// recon_sum_4x4: holds a 4x4 residual block and a 4x4 prediction block
// (either order, or together), then streams pred+res clipped rows out,
// one row per enabled cycle, tagged with the residual's block index.
// Optional build macro RECON_SAT_COUNT_EN adds a saturating count
// (sat_count) of clipped output samples.
module recon_sum_4x4 #(
  parameter int PIX_W = recon_pkg::PIX_W,
  parameter int RES_W = recon_pkg::RES_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          residual_valid,
  input  logic [16*RES_W-1:0]           residual_flat,
  input  logic [recon_pkg::TAG_W-1:0]   blk_idx_in,
  output logic                          res_ready,
  input  logic                          pred_valid,
  input  logic [16*PIX_W-1:0]           pred_flat,
  output logic                          pred_ready,
  output logic                          sum_row_valid,
  output logic [1:0]                    sum_row_idx,
  output logic [4*PIX_W-1:0]            sum_row,
  output logic [recon_pkg::TAG_W-1:0]   sum_blk_idx,
  output logic                          done,
  output logic                          busy
`ifdef RECON_SAT_COUNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);

  import recon_pkg::*;

  state_t               state;
  logic [1:0]           row_cnt;
  logic                 res_held;
  logic                 pred_held;
  logic [16*RES_W-1:0]  res_q;
  logic [16*PIX_W-1:0]  pred_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 res_take;
  logic                 pred_take;
  logic [4*PIX_W-1:0]   row_pix;
  logic [3:0]           row_clip;

  assign res_ready  = (state == ST_IDLE) && !res_held;
  assign pred_ready = (state == ST_IDLE) && !pred_held;
  assign busy       = res_held || pred_held || (state == ST_OUT);

  assign res_take  = ena && residual_valid && res_ready;
  assign pred_take = ena && pred_valid && pred_ready;

  // Capture block data; the held flags say whether it is meaningful.
  // NOTE: the block buffers carry no reset: they are only read while the
  // matching held flag (which is reset) is set, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (res_take) begin
      res_q <= residual_flat;
      tag_q <= blk_idx_in;
    end
    if (pred_take) begin
      pred_q <= pred_flat;
    end
  end

  // Four adders work on the row selected by row_cnt.
  for (genvar c = 0; c < 4; c++) begin : g_col
    recon_clip_add #(
      .PIX_W   (PIX_W),
      .RES_W   (RES_W),
      .PIX_MAX ((1 << PIX_W) - 1)
    ) u_clip (
      .pred    (pred_q[PIX_W*(4*int'(row_cnt) + c) +: PIX_W]),
      .res     ($signed(res_q[RES_W*(4*int'(row_cnt) + c) +: RES_W])),
      .pix     (row_pix[PIX_W*c +: PIX_W]),
      .clipped (row_clip[c])
    );
  end

  // Control FSM with registered row outputs; everything freezes when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      row_cnt       <= 2'd0;
      res_held      <= 1'b0;
      pred_held     <= 1'b0;
      sum_row_valid <= 1'b0;
      sum_row_idx   <= 2'd0;
      sum_row       <= '0;
      sum_blk_idx   <= '0;
      done          <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          sum_row_valid <= 1'b0;
          done          <= 1'b0;
          if (res_take)  res_held  <= 1'b1;
          if (pred_take) pred_held <= 1'b1;
          if ((res_held || res_take) && (pred_held || pred_take)) begin
            state   <= ST_OUT;
            row_cnt <= 2'd0;
          end
        end
        ST_OUT: begin
          sum_row_valid <= 1'b1;
          sum_row_idx   <= row_cnt;
          sum_row       <= row_pix;
          sum_blk_idx   <= tag_q;
          done          <= (row_cnt == 2'd3);
          row_cnt       <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) begin
            res_held  <= 1'b0;
            pred_held <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RECON_SAT_COUNT_EN
  logic [2:0]  clip_cnt;
  logic [16:0] sat_sum;

  // Number of clipped samples in the row about to be registered.
  always_comb begin
    clip_cnt = 3'd0;
    for (int c = 0; c < 4; c++) begin
      clip_cnt = clip_cnt + 3'(row_clip[c]);
    end
    sat_sum = {1'b0, sat_count} + 17'(clip_cnt);
  end

  // Saturating clip counter, advanced on every row-output edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 16'd0;
    end else if (ena && (state == ST_OUT)) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`else
  logic unused_clip;
  assign unused_clip = ^row_clip;
`endif

endmodule
